sal_multi_bk_ctrl: RTL

Parametrised multi-bank controller that tracks the row state of NUM_BANKS DRAM banks and enforces per-bank and inter-bank timing. Each cycle it picks one legal command (ACT/RD/WR/PRE/REF) from the banks by round-robin and issues it on a registered command bus toward the PHY scheduler. Two page policies are selectable by parameter: open-page with idle timeout, or closed-page. An open bank is precharged before it is refreshed.

---
 rtl/sal_multi_bk_pkg.sv | 22 ++
 rtl/sal_bank_fsm.sv | 119 +++++++++++
 rtl/sal_timing_cntr.sv | 34 +++
 rtl/sal_multi_bk_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sal_multi_bk_pkg.sv
// Shared command encoding, bank states and page-policy constants for the
// multi-bank DRAM controller.
package sal_multi_bk_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    typedef enum logic {
        BANK_CLOSED = 1'b0,
        BANK_OPEN   = 1'b1
    } bank_state_e;

    localparam int OPEN_PAGE   = 0;
    localparam int CLOSED_PAGE = 1;

endpackage

// File: rtl/sal_bank_fsm.sv
// One bank: CLOSED/OPEN state, open-row register, per-bank timing counters
// and the single command this bank would like to issue this cycle.
module sal_bank_fsm
    import sal_multi_bk_pkg::*;
#(
    parameter int RA_WIDTH    = 16,
    parameter int CNT_WIDTH   = 8,
    parameter int PAGE_POLICY = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic                 req_wr,
    input  logic [RA_WIDTH-1:0]  req_ra,
    input  logic                 ref_req,
    input  logic [CNT_WIDTH-1:0] t_rcd_m1,
    input  logic [CNT_WIDTH-1:0] t_rp_m1,
    input  logic [CNT_WIDTH-1:0] t_ras_m1,
    input  logic [CNT_WIDTH-1:0] t_rfc_m1,
    input  logic [CNT_WIDTH-1:0] t_rtp_m1,
    input  logic [CNT_WIDTH-1:0] t_wtp_m1,
    input  logic [CNT_WIDTH-1:0] row_open_cnt,
    input  logic                 rrd_met,
    input  logic                 ccd_met,
    input  logic                 rtw_met,
    input  logic                 wtr_met,
    input  logic                 grant,
    output logic                 cand_valid,
    output cmd_e                 cand_type
);

    bank_state_e          state_q, state_d;
    logic [RA_WIDTH-1:0]  open_row_q, open_row_d;
    logic rcd_met, rp_met, ras_met, rfc_met, rtp_met, wtp_met, row_open_met;
    logic ld_act, ld_pre, ld_ref, ld_rd, ld_wr;
    logic row_hit, pre_ok;

    assign ld_act = grant && (cand_type == CMD_ACT);
    assign ld_pre = grant && (cand_type == CMD_PRE);
    assign ld_ref = grant && (cand_type == CMD_REF);
    assign ld_rd  = grant && (cand_type == CMD_RD);
    assign ld_wr  = grant && (cand_type == CMD_WR);

    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_rcd (.clk(clk), .rst_n(rst_n), .load(ld_act), .load_val(t_rcd_m1), .met(rcd_met));
    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_ras (.clk(clk), .rst_n(rst_n), .load(ld_act), .load_val(t_ras_m1), .met(ras_met));
    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_rp  (.clk(clk), .rst_n(rst_n), .load(ld_pre), .load_val(t_rp_m1),  .met(rp_met));
    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_rfc (.clk(clk), .rst_n(rst_n), .load(ld_ref), .load_val(t_rfc_m1), .met(rfc_met));
    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_rtp (.clk(clk), .rst_n(rst_n), .load(ld_rd),  .load_val(t_rtp_m1), .met(rtp_met));
    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_wtp (.clk(clk), .rst_n(rst_n), .load(ld_wr),  .load_val(t_wtp_m1), .met(wtp_met));
    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_row_open (
        .clk(clk), .rst_n(rst_n), .load(ld_rd || ld_wr), .load_val(row_open_cnt), .met(row_open_met)
    );

    assign row_hit = (req_ra == open_row_q);
    assign pre_ok  = ras_met && rtp_met && wtp_met;

    // A refresh or row miss on an open bank must close the row first.
    always_comb begin
        cand_valid = 1'b0;
        cand_type  = CMD_NOP;
        case (state_q)
            BANK_CLOSED: begin
                if (rp_met && rfc_met && rrd_met) begin
                    if (ref_req) begin
                        cand_valid = 1'b1;
                        cand_type  = CMD_REF;
                    end else if (req_valid) begin
                        cand_valid = 1'b1;
                        cand_type  = CMD_ACT;
                    end
                end
            end
            BANK_OPEN: begin
                if (ref_req || (req_valid && !row_hit)) begin
                    if (pre_ok) begin
                        cand_valid = 1'b1;
                        cand_type  = CMD_PRE;
                    end
                end else if (req_valid) begin
                    if (req_wr) begin
                        if (rcd_met && ccd_met && rtw_met) begin
                            cand_valid = 1'b1;
                            cand_type  = CMD_WR;
                        end
                    end else if (rcd_met && ccd_met && wtr_met) begin
                        cand_valid = 1'b1;
                        cand_type  = CMD_RD;
                    end
                end else if (pre_ok && ((PAGE_POLICY == CLOSED_PAGE) || row_open_met)) begin
                    cand_valid = 1'b1;
                    cand_type  = CMD_PRE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        open_row_d = open_row_q;
        if (ld_act) begin
            state_d    = BANK_OPEN;
            open_row_d = req_ra;
        end else if (ld_pre) begin
            state_d = BANK_CLOSED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BANK_CLOSED;
            open_row_q <= '0;
        end else begin
            state_q    <= state_d;
            open_row_q <= open_row_d;
        end
    end

endmodule

// File: rtl/sal_timing_cntr.sv
// Loadable down-counter that saturates at zero; a timing constraint is met
// while the count is zero.
module sal_timing_cntr #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 met
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign met = (cnt_q == '0);

endmodule

// File: rtl/sal_multi_bk_ctrl.sv
// Multi-bank controller top: per-bank FSMs, shared inter-bank timers,
// round-robin command arbiter and the registered command bus.
module sal_multi_bk_ctrl
    import sal_multi_bk_pkg::*;
#(
    parameter int NUM_BANKS   = 4,
    parameter int RA_WIDTH    = 16,
    parameter int CA_WIDTH    = 10,
    parameter int ID_WIDTH    = 4,
    parameter int LEN_WIDTH   = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int PAGE_POLICY = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_BANKS-1:0]           req_valid,
    output logic [NUM_BANKS-1:0]           req_ready,
    input  logic [NUM_BANKS-1:0]           req_wr,
    input  logic [NUM_BANKS*RA_WIDTH-1:0]  req_ra,
    input  logic [NUM_BANKS*CA_WIDTH-1:0]  req_ca,
    input  logic [NUM_BANKS*ID_WIDTH-1:0]  req_id,
    input  logic [NUM_BANKS*LEN_WIDTH-1:0] req_len,
    input  logic [NUM_BANKS-1:0]           ref_req_i,
    output logic [NUM_BANKS-1:0]           ref_gnt_o,
    input  logic [CNT_WIDTH-1:0]           t_rcd_m1,
    input  logic [CNT_WIDTH-1:0]           t_rp_m1,
    input  logic [CNT_WIDTH-1:0]           t_ras_m1,
    input  logic [CNT_WIDTH-1:0]           t_rfc_m1,
    input  logic [CNT_WIDTH-1:0]           t_rtp_m1,
    input  logic [CNT_WIDTH-1:0]           t_wtp_m1,
    input  logic [CNT_WIDTH-1:0]           t_rrd_m1,
    input  logic [CNT_WIDTH-1:0]           t_ccd_m1,
    input  logic [CNT_WIDTH-1:0]           t_rtw_m1,
    input  logic [CNT_WIDTH-1:0]           t_wtr_m1,
    input  logic [CNT_WIDTH-1:0]           row_open_cnt,
    output logic                           cmd_valid,
    output logic [2:0]                     cmd_type,
    output logic [$clog2(NUM_BANKS)-1:0]   cmd_ba,
    output logic [RA_WIDTH-1:0]            cmd_ra,
    output logic [CA_WIDTH-1:0]            cmd_ca,
    output logic [ID_WIDTH-1:0]            cmd_id,
    output logic [LEN_WIDTH-1:0]           cmd_len
);

    localparam int BA_W = $clog2(NUM_BANKS);

    logic [NUM_BANKS-1:0] cand_valid, bank_gnt;
    cmd_e                 cand_type [NUM_BANKS];
    logic                 rrd_met, ccd_met, rtw_met, wtr_met;
    logic                 any_gnt;
    int                   gnt_idx, arb_idx;
    cmd_e                 gnt_type;
    logic [BA_W-1:0]      gnt_ba, rr_q, rr_d;

    logic                 cmd_valid_q, cmd_valid_d;
    cmd_e                 cmd_type_q, cmd_type_d;
    logic [BA_W-1:0]      cmd_ba_q, cmd_ba_d;
    logic [RA_WIDTH-1:0]  cmd_ra_q, cmd_ra_d;
    logic [CA_WIDTH-1:0]  cmd_ca_q, cmd_ca_d;
    logic [ID_WIDTH-1:0]  cmd_id_q, cmd_id_d;
    logic [LEN_WIDTH-1:0] cmd_len_q, cmd_len_d;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sal_bank_fsm #(
            .RA_WIDTH(RA_WIDTH), .CNT_WIDTH(CNT_WIDTH), .PAGE_POLICY(PAGE_POLICY)
        ) u_bank (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[b]), .req_wr(req_wr[b]),
            .req_ra(req_ra[b*RA_WIDTH +: RA_WIDTH]), .ref_req(ref_req_i[b]),
            .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1), .t_rfc_m1(t_rfc_m1),
            .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1), .row_open_cnt(row_open_cnt),
            .rrd_met(rrd_met), .ccd_met(ccd_met), .rtw_met(rtw_met), .wtr_met(wtr_met),
            .grant(bank_gnt[b]), .cand_valid(cand_valid[b]), .cand_type(cand_type[b])
        );
    end

    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_rrd (
        .clk(clk), .rst_n(rst_n), .load(any_gnt && (gnt_type == CMD_ACT)), .load_val(t_rrd_m1), .met(rrd_met)
    );
    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_ccd (
        .clk(clk), .rst_n(rst_n), .load(any_gnt && ((gnt_type == CMD_RD) || (gnt_type == CMD_WR))),
        .load_val(t_ccd_m1), .met(ccd_met)
    );
    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_rtw (
        .clk(clk), .rst_n(rst_n), .load(any_gnt && (gnt_type == CMD_RD)), .load_val(t_rtw_m1), .met(rtw_met)
    );
    sal_timing_cntr #(.CNT_WIDTH(CNT_WIDTH)) u_wtr (
        .clk(clk), .rst_n(rst_n), .load(any_gnt && (gnt_type == CMD_WR)), .load_val(t_wtr_m1), .met(wtr_met)
    );

    // First eligible bank at or after rr wins; nothing is granted in reset.
    always_comb begin
        any_gnt  = 1'b0;
        gnt_idx  = 0;
        arb_idx  = 0;
        gnt_type = CMD_NOP;
        bank_gnt = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            arb_idx = int'(rr_q) + i;
            if (arb_idx >= NUM_BANKS) begin
                arb_idx = arb_idx - NUM_BANKS;
            end
            if (!any_gnt && rst_n && cand_valid[arb_idx]) begin
                any_gnt  = 1'b1;
                gnt_idx  = arb_idx;
                gnt_type = cand_type[arb_idx];
            end
        end
        if (any_gnt) begin
            bank_gnt[gnt_idx] = 1'b1;
        end
    end

    assign gnt_ba    = BA_W'(gnt_idx);
    assign req_ready = ((gnt_type == CMD_RD) || (gnt_type == CMD_WR)) ? bank_gnt : '0;
    assign ref_gnt_o = (gnt_type == CMD_REF) ? bank_gnt : '0;

    always_comb begin
        rr_d        = rr_q;
        cmd_valid_d = any_gnt;
        cmd_type_d  = any_gnt ? gnt_type : CMD_NOP;
        cmd_ba_d    = cmd_ba_q;
        cmd_ra_d    = cmd_ra_q;
        cmd_ca_d    = cmd_ca_q;
        cmd_id_d    = cmd_id_q;
        cmd_len_d   = cmd_len_q;
        if (any_gnt) begin
            rr_d     = (gnt_ba == BA_W'(NUM_BANKS - 1)) ? '0 : gnt_ba + BA_W'(1);
            cmd_ba_d = gnt_ba;
            if ((gnt_type == CMD_ACT) || (gnt_type == CMD_RD) || (gnt_type == CMD_WR)) begin
                cmd_ra_d = req_ra[gnt_idx*RA_WIDTH +: RA_WIDTH];
            end
            if ((gnt_type == CMD_RD) || (gnt_type == CMD_WR)) begin
                cmd_ca_d  = req_ca[gnt_idx*CA_WIDTH +: CA_WIDTH];
                cmd_id_d  = req_id[gnt_idx*ID_WIDTH +: ID_WIDTH];
                cmd_len_d = req_len[gnt_idx*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_NOP;
            cmd_ba_q    <= '0;
            cmd_ra_q    <= '0;
            cmd_ca_q    <= '0;
            cmd_id_q    <= '0;
            cmd_len_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_ba_q    <= cmd_ba_d;
            cmd_ra_q    <= cmd_ra_d;
            cmd_ca_q    <= cmd_ca_d;
            cmd_id_q    <= cmd_id_d;
            cmd_len_q   <= cmd_len_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_ra    = cmd_ra_q;
    assign cmd_ca    = cmd_ca_q;
    assign cmd_id    = cmd_id_q;
    assign cmd_len   = cmd_len_q;

endmodule
